// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, programmable wait states, valid/ready response.
// Optional byte-strobe stores when DMEM_WSTRB_EN is defined.
module dmem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
`ifdef DMEM_WSTRB_EN
  input  logic [7:0]  req_wstrb,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) << 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             lWrite;
  logic [63:0]      lAddr, lWdata;
  logic             readyNext, validNext, errNext;
  logic [63:0]      rdataNext;
  logic             latch, doAccess;

  logic [63:0]      mem [DEPTH];

  // With zero wait states the access uses the live request on its acceptance edge.
  logic             accWrite, accErr, wrEn;
  logic [63:0]      accAddr, accWdata, mergedWord;
  logic [7:0]       accStrb;
  logic [IDX_W-1:0] accIdx;

  assign accWrite = (state == IDLE) ? req_write : lWrite;
  assign accAddr  = (state == IDLE) ? req_addr  : lAddr;
  assign accWdata = (state == IDLE) ? req_wdata : lWdata;
  assign accErr   = (accAddr[2:0] != 3'b000) || (accAddr >= ADDR_LIMIT);
  assign accIdx   = accAddr[3 +: IDX_W];
  assign wrEn     = doAccess && accWrite && !accErr;

`ifdef DMEM_WSTRB_EN
  logic [7:0] lWstrb;
  assign accStrb = (state == IDLE) ? req_wstrb : lWstrb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lWstrb <= '0;
    end else if (latch) begin
      lWstrb <= req_wstrb;
    end
  end
`else
  assign accStrb = 8'hFF;
`endif

  // Byte-merge of store data over the current word
  always_comb begin
    mergedWord = mem[accIdx];
    for (int b = 0; b < 8; b++) begin
      if (accStrb[b]) begin
        mergedWord[8*b +: 8] = accWdata[8*b +: 8];
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lWrite    <= 1'b0;
      lAddr     <= '0;
      lWdata    <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      req_ready <= readyNext;
      rsp_valid <= validNext;
      rsp_rdata <= rdataNext;
      rsp_err   <= errNext;
      if (latch) begin
        lWrite <= req_write;
        lAddr  <= req_addr;
        lWdata <= req_wdata;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    readyNext = req_ready;
    validNext = rsp_valid;
    rdataNext = rsp_rdata;
    errNext   = rsp_err;
    latch     = 1'b0;
    doAccess  = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid) begin
          latch     = 1'b1;
          readyNext = 1'b0;
          if (WAIT_CYCLES == 0) begin
            doAccess  = 1'b1;
            validNext = 1'b1;
            stateNext = RESP;
          end else begin
            cntNext   = WAIT_LOAD;
            stateNext = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          doAccess  = 1'b1;
          validNext = 1'b1;
          stateNext = RESP;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          validNext = 1'b0;
          rdataNext = '0;
          errNext   = 1'b0;
          readyNext = 1'b1;
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
        readyNext = 1'b1;
        validNext = 1'b0;
        rdataNext = '0;
        errNext   = 1'b0;
      end
    endcase

    if (doAccess) begin
      errNext   = accErr;
      rdataNext = (accErr || accWrite) ? '0 : mem[accIdx];
    end
  end

  // Storage array, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wrEn) begin
      mem[accIdx] <= mergedWord;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table, hand sequences and randomized
// traffic against a word-array reference model. Covers DMEM_WSTRB_EN when defined.
module tb_dmem_responder;

  localparam int unsigned DEPTH   = 64;
  localparam int unsigned WAITC   = 2;
  localparam int          TIMEOUT = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        reqValid, reqReady, reqWrite, rspValid, rspReady, rspErr;
  logic [63:0] reqAddr, reqWdata, rspRdata;
  logic        zReqValid, zReqReady, zReqWrite, zRspValid, zRspReady, zRspErr;
  logic [63:0] zReqAddr, zReqWdata, zRspRdata;
`ifdef DMEM_WSTRB_EN
  logic [7:0]  reqWstrb, zReqWstrb;
`endif

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(reqValid), .req_ready(reqReady), .req_write(reqWrite),
    .req_addr(reqAddr), .req_wdata(reqWdata),
`ifdef DMEM_WSTRB_EN
    .req_wstrb(reqWstrb),
`endif
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_rdata(rspRdata), .rsp_err(rspErr)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dutZero (
    .clk(clk), .rst_n(rst_n),
    .req_valid(zReqValid), .req_ready(zReqReady), .req_write(zReqWrite),
    .req_addr(zReqAddr), .req_wdata(zReqWdata),
`ifdef DMEM_WSTRB_EN
    .req_wstrb(zReqWstrb),
`endif
    .rsp_valid(zRspValid), .rsp_ready(zRspReady), .rsp_rdata(zRspRdata), .rsp_err(zRspErr)
  );

  int checks = 0;
  int failures = 0;

  logic [63:0] refMem [DEPTH];

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] expData;
    logic        expErr;
  } vec_t;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void clearModel();
    for (int i = 0; i < int'(DEPTH); i++) refMem[i] = '0;
  endfunction

  // Reference: byte address -> word array; misaligned or beyond the array is an error.
  function automatic void modelAccess(input logic wr, input logic [63:0] addr,
                                      input logic [63:0] wdata, input logic [7:0] strb,
                                      output logic [63:0] data, output logic err);
    int idx;
    err  = (addr % 64'd8 != 64'd0) || (addr >= 64'(DEPTH * 8));
    data = '0;
    if (!err) begin
      idx = int'(addr / 64'd8);
      if (wr) begin
        for (int b = 0; b < 8; b++)
          if (strb[b]) refMem[idx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        data = refMem[idx];
      end
    end
  endfunction

  task automatic issue(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] strb);
    int n = 0;
    while (!reqReady && n < TIMEOUT) begin @(posedge clk); #1; n++; end
    if (!reqReady) check64("req_ready_timeout", 64'(reqReady), 64'd1);
    reqValid = 1'b1; reqWrite = wr; reqAddr = addr; reqWdata = wdata;
`ifdef DMEM_WSTRB_EN
    reqWstrb = strb;
`else
    if (strb != 8'hFF) $display("note: strobe ignored in this build");
`endif
    @(posedge clk); #1;
    // Scramble the request bus; the latched request must be used.
    reqValid = 1'b0; reqWrite = 1'($urandom); reqAddr = {$urandom, $urandom};
    reqWdata = {$urandom, $urandom};
  endtask

  task automatic doTxn(input string name, input logic wr, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] strb, input int hold,
                       output logic [63:0] data, output logic err);
    int lat = 0;
    issue(wr, addr, wdata, strb);
    while (!rspValid && lat < TIMEOUT) begin @(posedge clk); #1; lat++; end
    if (!rspValid) check64({name, "_rsp_timeout"}, 64'(rspValid), 64'd1);
    // The cycle right after the acceptance edge counts as cycle 1.
    check64({name, "_latency_cycles"}, 64'(lat + 1), 64'(WAITC + 1));
    data = rspRdata; err = rspErr;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check64({name, "_hold_valid"}, 64'(rspValid), 64'd1);
      check64({name, "_hold_rdata"}, rspRdata, data);
      check64({name, "_hold_err"}, 64'(rspErr), 64'(err));
      check64({name, "_hold_req_ready"}, 64'(reqReady), 64'd0);
    end
    rspReady = 1'b1;
    @(posedge clk); #1;
    rspReady = 1'b0;
    check64({name, "_post_valid"}, 64'(rspValid), 64'd0);
    check64({name, "_post_req_ready"}, 64'(reqReady), 64'd1);
    check64({name, "_post_rdata"}, rspRdata, 64'd0);
  endtask

  vec_t        vecs[$];
  logic [63:0] gotData, expData;
  logic        gotErr, expErr;

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqWdata = '0; rspReady = 1'b0;
    zReqValid = 1'b0; zReqWrite = 1'b0; zReqAddr = '0; zReqWdata = '0; zRspReady = 1'b0;
`ifdef DMEM_WSTRB_EN
    reqWstrb = 8'hFF; zReqWstrb = 8'hFF;
`endif
    clearModel();
    repeat (2) @(posedge clk);
    #1;
    check64("reset_req_ready", 64'(reqReady), 64'd1);
    check64("reset_rsp_valid", 64'(rspValid), 64'd0);
    check64("reset_rsp_rdata", rspRdata, 64'd0);
    check64("reset_rsp_err", 64'(rspErr), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors: store/load, misaligned, out-of-range, last word, no aliasing.
    vecs.push_back('{1'b1, 64'h10,  64'hDEADBEEF_CAFEF00D, 64'h0, 1'b0});
    vecs.push_back('{1'b0, 64'h10,  64'h0,                 64'hDEADBEEF_CAFEF00D, 1'b0});
    vecs.push_back('{1'b0, 64'h0C,  64'h0,                 64'h0, 1'b1});
    vecs.push_back('{1'b1, 64'h200, 64'h12345678_9ABCDEF0, 64'h0, 1'b1});
    vecs.push_back('{1'b0, 64'h08,  64'h0,                 64'h0, 1'b0});
    vecs.push_back('{1'b1, 64'h1F8, 64'hAAAA5555_0F0F3C3C, 64'h0, 1'b0});
    vecs.push_back('{1'b0, 64'h1F8, 64'h0,                 64'hAAAA5555_0F0F3C3C, 1'b0});
    vecs.push_back('{1'b0, 64'h1F9, 64'h0,                 64'h0, 1'b1});
    vecs.push_back('{1'b1, 64'h1_0000_0010, 64'h77,        64'h0, 1'b1});
    vecs.push_back('{1'b0, 64'h10,  64'h0,                 64'hDEADBEEF_CAFEF00D, 1'b0});
    vecs.push_back('{1'b1, 64'h00,  64'h01020304_05060708, 64'h0, 1'b0});
    vecs.push_back('{1'b0, 64'h00,  64'h0,                 64'h01020304_05060708, 1'b0});
    foreach (vecs[i]) begin
      modelAccess(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 8'hFF, expData, expErr);
      doTxn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, 8'hFF, 0,
            gotData, gotErr);
      check64($sformatf("vec%0d_rdata", i), gotData, vecs[i].expData);
      check64($sformatf("vec%0d_err", i), 64'(gotErr), 64'(vecs[i].expErr));
    end

    // Backpressure: response held for 5 cycles with rsp_ready low.
    doTxn("hold", 1'b0, 64'h10, 64'h0, 8'hFF, 5, gotData, gotErr);
    check64("hold_rdata", gotData, 64'hDEADBEEF_CAFEF00D);
    check64("hold_err", 64'(gotErr), 64'd0);

    // Reset in the middle of a store's wait states.
    begin
      bit seen = 1'b0;
      issue(1'b1, 64'h20, 64'h55, 8'hFF);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check64("midrst_req_ready", 64'(reqReady), 64'd1);
      check64("midrst_rsp_valid", 64'(rspValid), 64'd0);
      check64("midrst_rsp_rdata", rspRdata, 64'd0);
      check64("midrst_rsp_err", 64'(rspErr), 64'd0);
      #1;
      rst_n = 1'b1;
      clearModel();
      repeat (5) begin @(posedge clk); #1; if (rspValid) seen = 1'b1; end
      check64("midrst_no_response", 64'(seen), 64'd0);
      doTxn("midrst_load20", 1'b0, 64'h20, 64'h0, 8'hFF, 0, gotData, gotErr);
      check64("midrst_load20_rdata", gotData, 64'd0);
      doTxn("midrst_load10", 1'b0, 64'h10, 64'h0, 8'hFF, 0, gotData, gotErr);
      check64("midrst_load10_cleared", gotData, 64'd0);
    end

`ifdef DMEM_WSTRB_EN
    // Byte strobes: low half replaced, high half kept; zero strobe writes nothing.
    modelAccess(1'b1, 64'h18, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, expData, expErr);
    doTxn("strb_full", 1'b1, 64'h18, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 0, gotData, gotErr);
    modelAccess(1'b1, 64'h18, 64'h11223344_55667788, 8'h0F, expData, expErr);
    doTxn("strb_low", 1'b1, 64'h18, 64'h11223344_55667788, 8'h0F, 0, gotData, gotErr);
    check64("strb_low_err", 64'(gotErr), 64'd0);
    modelAccess(1'b1, 64'h18, 64'h0, 8'h00, expData, expErr);
    doTxn("strb_none", 1'b1, 64'h18, 64'h0, 8'h00, 0, gotData, gotErr);
    check64("strb_none_err", 64'(gotErr), 64'd0);
    doTxn("strb_load", 1'b0, 64'h18, 64'h0, 8'hFF, 0, gotData, gotErr);
    check64("strb_load_rdata", gotData, 64'hFFFFFFFF_55667788);
`endif

    // Randomized traffic against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic        wr;
      logic [63:0] addr, wdata;
      logic [7:0]  strb;
      int          sel;
      wr    = 1'($urandom);
      wdata = {$urandom, $urandom};
      sel   = int'($urandom_range(0, 9));
      strb  = 8'hFF;
`ifdef DMEM_WSTRB_EN
      strb  = 8'($urandom);
`endif
      if (sel <= 6)      addr = 64'($urandom_range(0, DEPTH - 1)) * 64'd8;
      else if (sel == 7) addr = 64'($urandom_range(0, DEPTH * 8 - 1)) | 64'd1;
      else if (sel == 8) addr = 64'($urandom_range(DEPTH, 4 * DEPTH)) * 64'd8;
      else               addr = {1'b1, 31'($urandom), 32'($urandom)};
      modelAccess(wr, addr, wdata, strb, expData, expErr);
      doTxn($sformatf("rnd%0d", n), wr, addr, wdata, strb, int'($urandom_range(0, 2)),
            gotData, gotErr);
      check64($sformatf("rnd%0d_rdata", n), gotData, expData);
      check64($sformatf("rnd%0d_err", n), 64'(gotErr), 64'(expErr));
    end

    // Zero-wait instance: requests held back to back, response every other edge.
    begin
      logic [63:0] zAddr[8], zData[8], zExp[8];
      logic        zWr[8];
      int          idx = 0, nRsp = 0, lastCyc = -1, cyc = 0;
      bit          preReady;
      for (int i = 0; i < 4; i++) begin
        zWr[i] = 1'b1; zAddr[i] = 64'(i * 8); zData[i] = 64'h1000 + 64'(i * 3);
        zExp[i] = '0;
        zWr[i+4] = 1'b0; zAddr[i+4] = 64'(i * 8); zData[i+4] = '0;
        zExp[i+4] = zData[i];
      end
      zRspReady = 1'b1;
      zReqValid = 1'b1; zReqWrite = zWr[0]; zReqAddr = zAddr[0]; zReqWdata = zData[0];
      while (nRsp < 8 && cyc < 60) begin
        preReady = zReqReady;
        @(posedge clk); #1;
        cyc++;
        if (preReady && zReqValid) begin
          idx++;
          if (idx < 8) begin
            zReqWrite = zWr[idx]; zReqAddr = zAddr[idx]; zReqWdata = zData[idx];
          end else begin
            zReqValid = 1'b0;
          end
        end
        if (zRspValid) begin
          check64($sformatf("zero%0d_rdata", nRsp), zRspRdata, zExp[nRsp]);
          check64($sformatf("zero%0d_err", nRsp), 64'(zRspErr), 64'd0);
          if (lastCyc >= 0) check64($sformatf("zero%0d_spacing", nRsp), 64'(cyc - lastCyc), 64'd2);
          lastCyc = cyc;
          nRsp++;
        end
      end
      check64("zero_response_count", 64'(nRsp), 64'd8);
      check64("zero_accept_count", 64'(idx), 64'd8);
      @(posedge clk); #1;
      check64("zero_idle_valid", 64'(zRspValid), 64'd0);
      zRspReady = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
